// File: rtl/eth_rx_pkg.sv
// eth_rx_pkg: shared MII receive deframer state encoding and nibble constants
package eth_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA_LO,
        ST_DATA_HI,
        ST_DROP
    } rx_state_e;

    localparam logic [3:0] PREAMBLE_NIB = 4'h5;
    localparam logic [3:0] SFD_NIB      = 4'hD;

endpackage

// File: rtl/rx_mii_deframer.sv
// rx_mii_deframer: strips MII preamble/SFD and packs nibbles into a framed byte stream
module rx_mii_deframer
    import eth_rx_pkg::*;
#(
    parameter int MIN_PRE_NIB = 1,
    parameter int MAX_LEN     = 1518,
    parameter int LEN_W       = 16
) (
    input  logic             mrx_clk_pad_i,
    input  logic             rx_rst_n,
    input  logic [3:0]       mrxd_pad_i,
    input  logic             mrxdv_pad_i,
    input  logic             mrxerr_pad_i,
    output logic [7:0]       rx_data_o,
    output logic             rx_valid_o,
    output logic             rx_sof_o,
    output logic             rx_eof_o,
    output logic [LEN_W-1:0] rx_len_o,
    output logic             rx_err_o,
    output logic             rx_dribble_o,
    output logic             rx_busy_o
);

    localparam int               PRE_W   = $clog2(MIN_PRE_NIB + 1) + 1;
    localparam logic [PRE_W-1:0] PRE_MIN = PRE_W'(MIN_PRE_NIB);
    localparam logic [PRE_W-1:0] PRE_SAT = '1;
    localparam logic [LEN_W-1:0] LEN_SAT = '1;

    rx_state_e        r_state;
    logic [PRE_W-1:0] r_pre_cnt;
    logic [3:0]       r_lo;
    logic [LEN_W-1:0] r_len;
    logic             r_err;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_sof;
    logic             r_eof;
    logic [LEN_W-1:0] r_len_out;
    logic             r_err_out;
    logic             r_dribble;
    logic             r_busy;
    logic             w_err_eof;
    logic             w_err_now;

    // Frame error as it stands at end of frame: sticky PHY error, empty or oversize frame
    assign w_err_eof = r_err | (r_len == '0) | (32'(r_len) > MAX_LEN);
    // PHY error only counts while data is valid inside the frame body
    assign w_err_now = r_err | mrxerr_pad_i;

    // Deframer FSM: preamble hunt, nibble packing, end-of-frame status
    always_ff @(posedge mrx_clk_pad_i) begin
        if (!rx_rst_n) begin
            r_state   <= ST_IDLE;
            r_pre_cnt <= '0;
            r_lo      <= '0;
            r_len     <= '0;
            r_err     <= 1'b0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_sof     <= 1'b0;
            r_eof     <= 1'b0;
            r_len_out <= '0;
            r_err_out <= 1'b0;
            r_dribble <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_sof   <= 1'b0;
            r_eof   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (mrxdv_pad_i && mrxd_pad_i == PREAMBLE_NIB) begin
                        r_state   <= ST_PRE;
                        r_pre_cnt <= PRE_W'(1);
                        r_busy    <= 1'b1;
                    end else if (mrxdv_pad_i) begin
                        r_state <= ST_DROP;
                    end
                end
                ST_PRE: begin
                    if (!mrxdv_pad_i) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (mrxd_pad_i == PREAMBLE_NIB) begin
                        r_pre_cnt <= (r_pre_cnt == PRE_SAT) ? r_pre_cnt : r_pre_cnt + 1'b1;
                    end else if (mrxd_pad_i == SFD_NIB && r_pre_cnt >= PRE_MIN) begin
                        r_state <= ST_DATA_LO;
                        r_len   <= '0;
                        r_err   <= 1'b0;
                    end else begin
                        r_state <= ST_DROP;
                        r_busy  <= 1'b0;
                    end
                end
                ST_DATA_LO: begin
                    if (mrxdv_pad_i) begin
                        r_lo    <= mrxd_pad_i;
                        r_err   <= w_err_now;
                        r_state <= ST_DATA_HI;
                    end else begin
                        r_eof     <= 1'b1;
                        r_len_out <= r_len;
                        r_err_out <= w_err_eof;
                        r_dribble <= 1'b0;
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                    end
                end
                ST_DATA_HI: begin
                    if (mrxdv_pad_i) begin
                        r_data  <= {mrxd_pad_i, r_lo};
                        r_valid <= 1'b1;
                        r_sof   <= (r_len == '0);
                        r_len   <= (r_len == LEN_SAT) ? r_len : r_len + 1'b1;
                        r_err   <= w_err_now;
                        r_state <= ST_DATA_LO;
                    end else begin
                        r_eof     <= 1'b1;
                        r_len_out <= r_len;
                        r_err_out <= w_err_eof;
                        r_dribble <= 1'b1;
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                    end
                end
                ST_DROP: begin
                    if (!mrxdv_pad_i) r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data_o    = r_data;
    assign rx_valid_o   = r_valid;
    assign rx_sof_o     = r_sof;
    assign rx_eof_o     = r_eof;
    assign rx_len_o     = r_len_out;
    assign rx_err_o     = r_err_out;
    assign rx_dribble_o = r_dribble;
    assign rx_busy_o    = r_busy;

endmodule
